// File: rtl/bus_responder.sv
// Single-transfer bus responder: grants the bus on BR, forwards one read or write
// to a ready/timeout memory port, and returns read data on the shared D bus.
module bus_responder #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int WAIT_TIMEOUT  = 16   // legal range 2..255
) (
    input  logic                     CLK,
    input  logic                     RST,
    inout  wire  [DATA_WIDTH-1:0]    D,
    input  logic [ADDRESS_WIDTH-1:0] A,
    input  logic                     RW,
    input  logic                     FI,
    input  logic                     DT,
    input  logic                     BR,
    output logic                     BA,
    output logic [ADDRESS_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0]    MEM_WDATA,
    input  logic [DATA_WIDTH-1:0]    MEM_RDATA,
    output logic                     MEM_RE,
    output logic                     MEM_WE,
    input  logic                     MEM_READY,
    output logic                     ERR,
    output logic                     LAST_FI,
    output logic                     LAST_DT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(WAIT_TIMEOUT - 1);

    state_t                   r_state;
    logic                     r_ba;
    logic                     r_mem_re;
    logic                     r_mem_we;
    logic                     r_err;
    logic                     r_rw;
    logic                     r_last_fi;
    logic                     r_last_dt;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0]    r_mem_wdata;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic [7:0]               r_wait_cnt;

    logic                     w_cnt_last;
    logic                     w_d_oe;

    assign w_cnt_last = (r_wait_cnt == CNT_LAST);
    // D is only ever driven while returning data of a read
    assign w_d_oe     = (r_state == S_DONE) && r_rw;
    assign D          = w_d_oe ? r_rdata : {DATA_WIDTH{1'bz}};

    assign BA        = r_ba;
    assign MEM_RE    = r_mem_re;
    assign MEM_WE    = r_mem_we;
    assign ERR       = r_err;
    assign LAST_FI   = r_last_fi;
    assign LAST_DT   = r_last_dt;
    assign MEM_ADDR  = r_mem_addr;
    assign MEM_WDATA = r_mem_wdata;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_ba        <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_err       <= 1'b0;
            r_rw        <= 1'b0;
            r_last_fi   <= 1'b0;
            r_last_dt   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_wait_cnt  <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (BR) begin
                        r_state <= S_ADDR;
                        r_ba    <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (!BR) begin
                        r_state <= S_IDLE;
                        r_ba    <= 1'b0;
                    end else begin
                        r_state     <= S_WAIT;
                        r_mem_addr  <= A;
                        r_mem_wdata <= D;
                        r_rw        <= RW;
                        r_last_fi   <= FI;
                        r_last_dt   <= DT;
                        r_wait_cnt  <= '0;
                        r_mem_re    <= RW;
                        r_mem_we    <= !RW;
                    end
                end
                S_WAIT: begin
                    if (!BR) begin
                        r_state  <= S_IDLE;
                        r_ba     <= 1'b0;
                        r_mem_re <= 1'b0;
                        r_mem_we <= 1'b0;
                    end else if (MEM_READY) begin
                        // ready on the final count still counts as a success
                        r_state  <= S_DONE;
                        r_mem_re <= 1'b0;
                        r_mem_we <= 1'b0;
                        if (r_rw) begin
                            r_rdata <= MEM_RDATA;
                        end
                    end else if (w_cnt_last) begin
                        r_state  <= S_DONE;
                        r_mem_re <= 1'b0;
                        r_mem_we <= 1'b0;
                        r_rdata  <= '1;
                        r_err    <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ba    <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_ba     <= 1'b0;
                    r_mem_re <= 1'b0;
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: per-cycle vector table plus hand-built
// sequences for timeout, ready-at-limit and reset in the middle of a transfer.
module tb_bus_responder;

    // D carries a pulldown, so an undriven bus reads as zero
    localparam logic [7:0] Z_SEEN = 8'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a = '0;
    logic        rw = 1'b0;
    logic        fi = 1'b0;
    logic        dt = 1'b0;
    logic        br = 1'b0;
    logic        ba;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_re;
    logic        mem_we;
    logic        mem_ready = 1'b0;
    logic        err;
    logic        last_fi;
    logic        last_dt;

    wire  [7:0]  d_bus;
    logic        tb_d_oe = 1'b0;
    logic [7:0]  tb_d = '0;

    assign d_bus = tb_d_oe ? tb_d : 8'bz;

    for (genvar gi = 0; gi < 8; gi++) begin : g_pd
        pulldown (d_bus[gi]);
    end

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bus_responder #(
        .ADDRESS_WIDTH(16),
        .DATA_WIDTH   (8),
        .WAIT_TIMEOUT (16)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .D        (d_bus),
        .A        (a),
        .RW       (rw),
        .FI       (fi),
        .DT       (dt),
        .BR       (br),
        .BA       (ba),
        .MEM_ADDR (mem_addr),
        .MEM_WDATA(mem_wdata),
        .MEM_RDATA(mem_rdata),
        .MEM_RE   (mem_re),
        .MEM_WE   (mem_we),
        .MEM_READY(mem_ready),
        .ERR      (err),
        .LAST_FI  (last_fi),
        .LAST_DT  (last_dt)
    );

    typedef struct {
        string       tag;
        logic        rst;
        logic        br;
        logic [15:0] a;
        logic        rw;
        logic        fi;
        logic        dt;
        logic        d_oe;
        logic [7:0]  d_in;
        logic        rdy;
        logic [7:0]  rdata;
        logic        e_ba;
        logic        e_re;
        logic        e_we;
        logic        e_err;
        logic [7:0]  e_d;
        logic        e_lfi;
        logic        e_ldt;
        logic [15:0] e_addr;
        logic [7:0]  e_wdata;
    } vec_t;

    // inputs: rst br a rw fi dt d_oe d_in rdy rdata
    // expected outputs this cycle: ba re we err d lfi ldt mem_addr mem_wdata
    function automatic vec_t mk(
        input string tag, input logic v_rst, input logic v_br, input logic [15:0] v_a,
        input logic v_rw, input logic v_fi, input logic v_dt, input logic v_d_oe,
        input logic [7:0] v_d_in, input logic v_rdy, input logic [7:0] v_rdata,
        input logic x_ba, input logic x_re, input logic x_we, input logic x_err,
        input logic [7:0] x_d, input logic x_lfi, input logic x_ldt,
        input logic [15:0] x_addr, input logic [7:0] x_wdata);
        vec_t v;
        v.tag = tag;   v.rst = v_rst; v.br = v_br; v.a = v_a; v.rw = v_rw;
        v.fi = v_fi;   v.dt = v_dt;   v.d_oe = v_d_oe; v.d_in = v_d_in;
        v.rdy = v_rdy; v.rdata = v_rdata;
        v.e_ba = x_ba; v.e_re = x_re; v.e_we = x_we; v.e_err = x_err; v.e_d = x_d;
        v.e_lfi = x_lfi; v.e_ldt = x_ldt; v.e_addr = x_addr; v.e_wdata = x_wdata;
        return v;
    endfunction

    // Drive one cycle's inputs, compare outputs mid-cycle, advance to the next cycle.
    task automatic apply(input vec_t v);
        logic [37:0] act;
        logic [37:0] exp_v;
        rst = v.rst; br = v.br; a = v.a; rw = v.rw; fi = v.fi; dt = v.dt;
        tb_d_oe = v.d_oe; tb_d = v.d_in; mem_ready = v.rdy; mem_rdata = v.rdata;
        @(negedge clk);
        act   = {ba, mem_re, mem_we, err, d_bus, last_fi, last_dt, mem_addr, mem_wdata};
        exp_v = {v.e_ba, v.e_re, v.e_we, v.e_err, v.e_d, v.e_lfi, v.e_ldt, v.e_addr, v.e_wdata};
        n_checks++;
        if (act !== exp_v) begin
            $display("FAIL %s: got ba=%b re=%b we=%b err=%b d=%h lfi=%b ldt=%b addr=%h wdata=%h; want ba=%b re=%b we=%b err=%b d=%h lfi=%b ldt=%b addr=%h wdata=%h",
                     v.tag, ba, mem_re, mem_we, err, d_bus, last_fi, last_dt, mem_addr, mem_wdata,
                     v.e_ba, v.e_re, v.e_we, v.e_err, v.e_d, v.e_lfi, v.e_ldt, v.e_addr, v.e_wdata);
        end else begin
            n_pass++;
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        // reset and zero-wait read of 0x5A from 0x1234
        vecs.push_back(mk("reset",     1,0,16'h0000,0,0,0,0,8'h00,0,8'h00, 0,0,0,0,Z_SEEN,0,0,16'h0000,8'h00));
        vecs.push_back(mk("rd0_idle",  0,1,16'h0000,0,0,0,0,8'h00,0,8'h00, 0,0,0,0,Z_SEEN,0,0,16'h0000,8'h00));
        vecs.push_back(mk("rd0_addr",  0,1,16'h1234,1,0,0,1,8'h11,0,8'h00, 1,0,0,0,8'h11, 0,0,16'h0000,8'h00));
        vecs.push_back(mk("rd0_wait",  0,1,16'h0000,0,0,0,0,8'h00,1,8'h5A, 1,1,0,0,Z_SEEN,0,0,16'h1234,8'h11));
        vecs.push_back(mk("rd0_done",  0,0,16'h0000,0,0,0,0,8'h00,0,8'h00, 1,0,0,0,8'h5A, 0,0,16'h1234,8'h11));
        vecs.push_back(mk("rd0_after", 0,0,16'h0000,0,0,0,0,8'h00,0,8'h00, 0,0,0,0,Z_SEEN,0,0,16'h1234,8'h11));
        // write 0xC3 to 0x8001 with ready on the third WAIT cycle; ready outside WAIT ignored
        vecs.push_back(mk("wr3_idle",  0,1,16'h0000,0,0,0,0,8'h00,1,8'h00, 0,0,0,0,Z_SEEN,0,0,16'h1234,8'h11));
        vecs.push_back(mk("wr3_addr",  0,1,16'h8001,0,0,0,1,8'hC3,1,8'h00, 1,0,0,0,8'hC3, 0,0,16'h1234,8'h11));
        vecs.push_back(mk("wr3_wait1", 0,1,16'h0000,0,0,0,0,8'h00,0,8'h00, 1,0,1,0,Z_SEEN,0,0,16'h8001,8'hC3));
        vecs.push_back(mk("wr3_wait2", 0,1,16'h0000,0,0,0,0,8'h00,0,8'h00, 1,0,1,0,Z_SEEN,0,0,16'h8001,8'hC3));
        vecs.push_back(mk("wr3_wait3", 0,1,16'h0000,0,0,0,0,8'h00,1,8'h77, 1,0,1,0,Z_SEEN,0,0,16'h8001,8'hC3));
        vecs.push_back(mk("wr3_done",  0,0,16'h0000,0,0,0,0,8'h00,0,8'h00, 1,0,0,0,Z_SEEN,0,0,16'h8001,8'hC3));
        vecs.push_back(mk("wr3_after", 0,0,16'h0000,0,0,0,0,8'h00,1,8'h00, 0,0,0,0,Z_SEEN,0,0,16'h8001,8'hC3));
        // abort: BR low sampled at the end of the second WAIT cycle
        vecs.push_back(mk("abt_idle",  0,1,16'h0000,0,0,0,0,8'h00,0,8'h00, 0,0,0,0,Z_SEEN,0,0,16'h8001,8'hC3));
        vecs.push_back(mk("abt_addr",  0,1,16'h0042,1,1,0,1,8'h22,0,8'h00, 1,0,0,0,8'h22, 0,0,16'h8001,8'hC3));
        vecs.push_back(mk("abt_wait1", 0,1,16'h0000,0,0,0,0,8'h00,0,8'h00, 1,1,0,0,Z_SEEN,1,0,16'h0042,8'h22));
        vecs.push_back(mk("abt_wait2", 0,0,16'h0000,0,0,0,0,8'h00,0,8'h00, 1,1,0,0,Z_SEEN,1,0,16'h0042,8'h22));
        vecs.push_back(mk("abt_after", 0,0,16'h0000,0,0,0,0,8'h00,0,8'h00, 0,0,0,0,Z_SEEN,1,0,16'h0042,8'h22));
        vecs.push_back(mk("abt_idle2", 0,0,16'h0000,0,0,0,0,8'h00,0,8'h00, 0,0,0,0,Z_SEEN,1,0,16'h0042,8'h22));
        // back-to-back with BR held: FI read, one BA=0 cycle, then DT write
        vecs.push_back(mk("b2b_idle",  0,1,16'h0000,0,0,0,0,8'h00,0,8'h00, 0,0,0,0,Z_SEEN,1,0,16'h0042,8'h22));
        vecs.push_back(mk("b2b_addr1", 0,1,16'h0100,1,1,0,1,8'h5F,0,8'h00, 1,0,0,0,8'h5F, 1,0,16'h0042,8'h22));
        vecs.push_back(mk("b2b_wait1", 0,1,16'h0000,0,0,0,0,8'h00,1,8'h3C, 1,1,0,0,Z_SEEN,1,0,16'h0100,8'h5F));
        vecs.push_back(mk("b2b_done1", 0,1,16'h0000,0,0,0,0,8'h00,0,8'h00, 1,0,0,0,8'h3C, 1,0,16'h0100,8'h5F));
        vecs.push_back(mk("b2b_gap",   0,1,16'h0000,0,0,0,0,8'h00,0,8'h00, 0,0,0,0,Z_SEEN,1,0,16'h0100,8'h5F));
        vecs.push_back(mk("b2b_addr2", 0,1,16'h0200,0,0,1,1,8'hA5,0,8'h00, 1,0,0,0,8'hA5, 1,0,16'h0100,8'h5F));
        vecs.push_back(mk("b2b_wait2", 0,1,16'h0000,0,0,0,0,8'h00,1,8'h00, 1,0,1,0,Z_SEEN,0,1,16'h0200,8'hA5));
        vecs.push_back(mk("b2b_done2", 0,0,16'h0000,0,0,0,0,8'h00,0,8'h00, 1,0,0,0,Z_SEEN,0,1,16'h0200,8'hA5));
        vecs.push_back(mk("b2b_after", 0,0,16'h0000,0,0,0,0,8'h00,0,8'h00, 0,0,0,0,Z_SEEN,0,1,16'h0200,8'hA5));

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            if (i + 1 == vecs.size() || vecs[i + 1].tag.substr(0, 2) != vecs[i].tag.substr(0, 2))
                $display("txn %s complete", vecs[i].tag.substr(0, 2));
        end

        // timeout read: 16 WAIT cycles, ERR once, all-ones data in DONE
        apply(mk("to_idle", 0,1,16'h0000,0,0,0,0,8'h00,0,8'h00, 0,0,0,0,Z_SEEN,0,1,16'h0200,8'hA5));
        apply(mk("to_addr", 0,1,16'h0F0F,1,0,0,1,8'h44,0,8'h00, 1,0,0,0,8'h44, 0,1,16'h0200,8'hA5));
        for (int k = 1; k <= 16; k++)
            apply(mk($sformatf("to_wait%0d", k), 0,1,16'h0000,0,0,0,0,8'h00,0,8'h00, 1,1,0,0,Z_SEEN,0,0,16'h0F0F,8'h44));
        apply(mk("to_done", 0,0,16'h0000,0,0,0,0,8'h00,0,8'h00, 1,0,0,1,8'hFF, 0,0,16'h0F0F,8'h44));
        apply(mk("to_after",0,0,16'h0000,0,0,0,0,8'h00,0,8'h00, 0,0,0,0,Z_SEEN,0,0,16'h0F0F,8'h44));
        $display("txn timeout complete");

        // ready arriving on the final count is a success
        apply(mk("lim_idle", 0,1,16'h0000,0,0,0,0,8'h00,0,8'h00, 0,0,0,0,Z_SEEN,0,0,16'h0F0F,8'h44));
        apply(mk("lim_addr", 0,1,16'h0F10,1,1,1,1,8'h55,0,8'h00, 1,0,0,0,8'h55, 0,0,16'h0F0F,8'h44));
        for (int k = 1; k <= 15; k++)
            apply(mk($sformatf("lim_wait%0d", k), 0,1,16'h0000,0,0,0,0,8'h00,0,8'h00, 1,1,0,0,Z_SEEN,1,1,16'h0F10,8'h55));
        apply(mk("lim_wait16",0,1,16'h0000,0,0,0,0,8'h00,1,8'h96, 1,1,0,0,Z_SEEN,1,1,16'h0F10,8'h55));
        apply(mk("lim_done", 0,0,16'h0000,0,0,0,0,8'h00,0,8'h00, 1,0,0,0,8'h96, 1,1,16'h0F10,8'h55));
        apply(mk("lim_after",0,0,16'h0000,0,0,0,0,8'h00,0,8'h00, 0,0,0,0,Z_SEEN,1,1,16'h0F10,8'h55));
        $display("txn ready_at_limit complete");

        // reset in the second WAIT cycle wins over BR and MEM_READY, then a normal read
        apply(mk("rst_idle", 0,1,16'h0000,0,0,0,0,8'h00,0,8'h00, 0,0,0,0,Z_SEEN,1,1,16'h0F10,8'h55));
        apply(mk("rst_addr", 0,1,16'h0ABC,1,1,0,1,8'h66,0,8'h00, 1,0,0,0,8'h66, 1,1,16'h0F10,8'h55));
        apply(mk("rst_wait1",0,1,16'h0000,0,0,0,0,8'h00,0,8'h00, 1,1,0,0,Z_SEEN,1,0,16'h0ABC,8'h66));
        apply(mk("rst_wait2",1,1,16'h0000,0,0,0,0,8'h00,1,8'h12, 1,1,0,0,Z_SEEN,1,0,16'h0ABC,8'h66));
        apply(mk("rst_post", 0,1,16'h0000,0,0,0,0,8'h00,0,8'h00, 0,0,0,0,Z_SEEN,0,0,16'h0000,8'h00));
        apply(mk("rst_addr2",0,1,16'h0321,1,0,1,1,8'h77,0,8'h00, 1,0,0,0,8'h77, 0,0,16'h0000,8'h00));
        apply(mk("rst_wait3",0,1,16'h0000,0,0,0,0,8'h00,1,8'hE7, 1,1,0,0,Z_SEEN,0,1,16'h0321,8'h77));
        apply(mk("rst_done", 0,0,16'h0000,0,0,0,0,8'h00,0,8'h00, 1,0,0,0,8'hE7, 0,1,16'h0321,8'h77));
        apply(mk("rst_after",0,0,16'h0000,0,0,0,0,8'h00,0,8'h00, 0,0,0,0,Z_SEEN,0,1,16'h0321,8'h77));
        $display("txn reset_mid_wait complete");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
